// File: rtl/risc_toy_fetch.sv
// Instruction-fetch stage: owns the fetch PC, drives the instruction-memory port and
// presents one registered instruction per cycle to decode, with a one-entry skid buffer.
module risc_toy_fetch #(
  parameter int unsigned         AW       = 30,
  parameter int unsigned         DW       = 32,
  parameter logic [AW-1:0]       RESET_PC = '0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic          o_ireq,
  output logic [AW-1:0] o_iaddr,
  input  logic [DW-1:0] i_instr,
  input  logic          i_stall,
  input  logic          i_redirect,
  input  logic [AW-1:0] i_redirect_addr,
  output logic          o_fd_valid,
  output logic [DW-1:0] o_fd_instr,
  output logic [AW-1:0] o_fd_iaddr,
  output logic [AW-1:0] o_fd_iaddr_next
);

  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] r_pc;
  logic          r_req_q;
  logic          r_squash_q;
  logic [AW-1:0] r_resp_iaddr;
  logic          r_skid_valid;
  logic [DW-1:0] r_skid_instr;
  logic [AW-1:0] r_skid_iaddr;
  logic          r_fd_valid;
  logic [DW-1:0] r_fd_instr;
  logic [AW-1:0] r_fd_iaddr;

  logic w_resp_live;
  logic w_fd_take;

  assign w_resp_live = r_req_q & ~r_squash_q;
  // FD may load whenever it is empty: a stalled decode never blocks a bubble.
  assign w_fd_take   = ~i_stall | ~r_fd_valid;

  // Stop requesting as soon as one response could have nowhere to go but the skid.
  assign o_ireq = ~i_rst & ~(i_stall & r_skid_valid)
                         & ~(i_stall & r_fd_valid & w_resp_live);
  assign o_iaddr = r_pc;

  assign o_fd_valid      = r_fd_valid;
  assign o_fd_instr      = r_fd_instr;
  assign o_fd_iaddr      = r_fd_iaddr;
  assign o_fd_iaddr_next = r_fd_iaddr + ADDR_ONE;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc         <= RESET_PC;
      r_req_q      <= 1'b0;
      r_squash_q   <= 1'b0;
      r_resp_iaddr <= '0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_iaddr <= '0;
      r_fd_valid   <= 1'b0;
      r_fd_instr   <= '0;
      r_fd_iaddr   <= '0;
    end else begin
      r_req_q <= o_ireq;
      if (o_ireq) begin
        r_resp_iaddr <= r_pc;
      end
      if (i_redirect) begin
        // The old-PC request issued this cycle is wrong-path; mark it for dropping.
        r_pc         <= i_redirect_addr;
        r_fd_valid   <= 1'b0;
        r_skid_valid <= 1'b0;
        r_squash_q   <= o_ireq;
      end else begin
        r_squash_q <= 1'b0;
        if (o_ireq) begin
          r_pc <= r_pc + ADDR_ONE;
        end
        if (w_fd_take) begin
          if (r_skid_valid) begin
            r_fd_instr   <= r_skid_instr;
            r_fd_iaddr   <= r_skid_iaddr;
            r_fd_valid   <= 1'b1;
            r_skid_valid <= w_resp_live;
            if (w_resp_live) begin
              r_skid_instr <= i_instr;
              r_skid_iaddr <= r_resp_iaddr;
            end
          end else if (w_resp_live) begin
            r_fd_instr <= i_instr;
            r_fd_iaddr <= r_resp_iaddr;
            r_fd_valid <= 1'b1;
          end else begin
            r_fd_valid <= 1'b0;
          end
        end else if (w_resp_live && !r_skid_valid) begin
          r_skid_instr <= i_instr;
          r_skid_iaddr <= r_resp_iaddr;
          r_skid_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/risc_toy_fetch.md
Name: risc_toy_fetch

Overview:
- Instruction-fetch stage of the RISC_TOY pipeline. It sits upstream of the IF/ID decode stage and drives the instruction-memory port (IREQ/IADDR/INSTR).
- It owns the fetch PC and presents one instruction per cycle to decode through a registered FD_* interface with a valid bit.
- It absorbs decode stalls with a one-entry skid buffer and handles branch/jump redirects from execute, squashing wrong-path fetches.

Parameters:
AW, 30, word-address width of IADDR, FD_IADDR and REDIRECT_ADDR
DW, 32, instruction width
RESET_PC, 0, word address fetched first after reset

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  synchronous, active-high reset
IREQ  output  1  instruction-memory request; combinational
IADDR  output  AW  word address of the request; equals the PC register
INSTR  input  DW  memory data, valid in cycle t+1 for a request issued in cycle t
STALL  input  1  decode cannot accept a new instruction this cycle
REDIRECT  input  1  one-cycle pulse from execute: taken branch or jump
REDIRECT_ADDR  input  AW  target word address, sampled when REDIRECT=1
FD_VALID  output  1  FD_INSTR/FD_IADDR hold a live instruction
FD_INSTR  output  DW  registered instruction to decode
FD_IADDR  output  AW  word address of FD_INSTR
FD_IADDR_NEXT  output  AW  FD_IADDR+1 (mod 2^AW); link value for BRL/JL

Behaviour:
- Clock, reset and polarity: one clock, CLK. Reset is synchronous and active-high on RST.
- Reset values, with RST=1 at a rising edge:
  - PC=RESET_PC
  - FD_VALID=0, FD_INSTR=0, FD_IADDR=0
  - skid_valid=0, req_q=0, squash_q=0
  - While RST=1, IREQ=0.
  - Reset mid-operation discards in-flight, skid and FD contents. The response arriving in the cycle after reset deassertion is ignored (req_q=0).
- Internal state:
  - PC
  - req_q: request issued last cycle
  - squash_q: in-flight response is wrong-path
  - skid_valid, skid_instr, skid_iaddr
  - resp_iaddr: address of the in-flight request
- resp_live = req_q & ~squash_q. INSTR is consumed only when resp_live=1.
- IREQ = ~RST & ~(STALL & skid_valid) & ~(STALL & FD_VALID & resp_live). This guarantees at most one un-consumable response, which always fits in the skid.
- PC update:
  - PC <= PC+1 on every cycle with IREQ=1.
  - PC wraps from 2^AW-1 to 0; no error is flagged.
  - PC holds otherwise.
- FD load, when REDIRECT=0 and (~STALL | ~FD_VALID):
  - If skid_valid: FD <= skid, FD_VALID<=1, skid_valid<=0.
    - In this case, if resp_live: skid <= {INSTR, resp_iaddr}, skid_valid<=1.
  - Else if resp_live: FD <= {INSTR, resp_iaddr}, FD_VALID<=1.
  - Else: FD_VALID<=0 (bubble). FD_INSTR and FD_IADDR hold their values.
- Stall with FD_VALID=1:
  - FD holds.
  - If resp_live and skid is empty: skid <= response.
  - A response never arrives while the skid is full.
- Bubble compression: STALL is ignored when FD_VALID=0.
- REDIRECT, which has priority over STALL and all loads:
  - At the edge: PC<=REDIRECT_ADDR, FD_VALID<=0, skid_valid<=0, squash_q<=IREQ.
  - In the redirect cycle IREQ is still evaluated normally with the old PC; that response is dropped.
  - squash_q clears the following cycle.
- Latency:
  - Reset deasserted in cycle r: IREQ=1 with IADDR=RESET_PC in cycle r; FD_VALID=1 from cycle r+2.
  - REDIRECT in cycle t: IADDR=target in cycle t+1; target is in FD in cycle t+3. Penalty is two bubbles.
- Steady state: one instruction per cycle with no stall and no redirect.

Test Plan:
- Reset then free-run:
  - Stimulus: RST high 2 cycles, low from r; memory returns 32'h1000_0000+addr.
  - Required: IADDR=0,1,2… from r; FD_VALID rises at r+2 with FD_IADDR=0, FD_INSTR=32'h1000_0000, FD_IADDR_NEXT=1; one instruction per cycle after that.
- Stall 3 cycles while FD holds address 5:
  - Required: FD holds 5; address 6 lands in the skid; IREQ=0 during the stall.
  - On STALL release: FD shows 6 then 7 on consecutive cycles; no instruction lost or duplicated.
- Redirect:
  - Stimulus: REDIRECT with REDIRECT_ADDR=0x40 while FD shows 3.
  - Required: next cycle IADDR=0x40; FD_VALID=0 for 2 cycles; then FD_IADDR=0x40, 0x41…; the response for 4 or 5 never appears.
- Redirect during stall with a full skid:
  - Required: skid and FD are dropped; IADDR=target next cycle; STALL is ignored because FD_VALID=0.
- Wrap-around:
  - Stimulus: REDIRECT_ADDR=30'h3FFF_FFFF.
  - Required: FD_IADDR=30'h3FFF_FFFF with FD_IADDR_NEXT=0; the next FD_IADDR=0.
- Reset mid-stream:
  - Stimulus: RST=1 for one cycle with the skid full and a request in flight.
  - Required: all outputs return to reset values; after release, fetch restarts at RESET_PC; no stale instruction appears on FD.
